// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: serialises one R-lane vector load/store into R single-lane
// accesses on a synchronous data-memory port, stalling the pipeline meanwhile.
// Optional feature macro: VMEM_SEQ_PERF_EN enables the saturating StallCycles
// counter; without it StallCycles is tied to zero.
module vec_mem_sequencer #(
    parameter int I = 32,
    parameter int N = 8,
    parameter int R = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReqM,
    input  logic                  MemWriteM,
    input  logic [I-1:0]          AddrM,
    input  logic [R-1:0][N-1:0]   WriteDataM,
    output logic [I-1:0]          MemAddr,
    output logic                  MemWE,
    output logic [N-1:0]          MemWD,
    input  logic [N-1:0]          MemRD,
    output logic [R-1:0][N-1:0]   ReadDataM,
    output logic                  StallM,
    output logic                  DoneM,
    output logic [31:0]           StallCycles
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(R - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [I-1:0]           r_base;
    logic                   r_isStore;
    logic [R-1:0][N-1:0]    r_wdata;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          r_cap;
    logic [R-1:0][N-1:0]    r_readData;
    logic [I-1:0]           w_laneOffset;

    assign w_laneOffset = {{(I-CW){1'b0}}, r_cnt};
    assign ReadDataM    = r_readData;

    // State register; reset always returns to IDLE, aborting any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection: stores finish after the last issue, loads need one drain cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (MemReqM) w_nextState = ACCESS;
            ACCESS:  if (r_cnt == LAST_LANE) w_nextState = r_isStore ? DONE : DRAIN;
            DRAIN:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Memory-port drive and pipeline handshake, all combinational from state.
    always_comb begin
        MemAddr = '0;
        MemWE   = 1'b0;
        MemWD   = '0;
        StallM  = 1'b0;
        DoneM   = 1'b0;
        case (r_state)
            IDLE: begin
                StallM = MemReqM;
            end
            ACCESS: begin
                StallM  = 1'b1;
                MemAddr = r_base + w_laneOffset;
                if (r_isStore) begin
                    MemWE = 1'b1;
                    MemWD = r_wdata[r_cnt];
                end
            end
            DRAIN: begin
                StallM = 1'b1;
            end
            DONE: begin
                DoneM = 1'b1;
            end
            default: begin
                StallM = 1'b0;
            end
        endcase
    end

    // Request latching, lane counters and load-data capture one cycle behind issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_base     <= '0;
            r_isStore  <= 1'b0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_cap      <= '0;
            r_readData <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (MemReqM) begin
                        r_base    <= AddrM;
                        r_isStore <= MemWriteM;
                        r_wdata   <= WriteDataM;
                        r_cnt     <= '0;
                        r_cap     <= '0;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_cap <= r_cnt;
                    if (!r_isStore && (r_cnt != '0)) begin
                        r_readData[r_cap] <= MemRD;
                    end
                end
                DRAIN: begin
                    r_readData[r_cap] <= MemRD;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

`ifdef VMEM_SEQ_PERF_EN
    logic [31:0] r_stallCycles;

    // Saturating count of cycles in which the pipeline is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
        end else if (StallM && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign StallCycles = r_stallCycles;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard testbench for vec_mem_sequencer: stimulus pushes expected lane
// accesses and completion records; a negedge monitor pops and compares them.
module tb_vec_mem_sequencer;

    localparam int I = 32;
    localparam int N = 8;
    localparam int R = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 MemReqM;
    logic                 MemWriteM;
    logic [I-1:0]         AddrM;
    logic [R-1:0][N-1:0]  WriteDataM;
    logic [I-1:0]         MemAddr;
    logic                 MemWE;
    logic [N-1:0]         MemWD;
    logic [N-1:0]         MemRD;
    logic [R-1:0][N-1:0]  ReadDataM;
    logic                 StallM;
    logic                 DoneM;
    logic [31:0]          StallCycles;

    vec_mem_sequencer #(.I(I), .N(N), .R(R)) dut (
        .clk(clk),
        .reset(reset),
        .MemReqM(MemReqM),
        .MemWriteM(MemWriteM),
        .AddrM(AddrM),
        .WriteDataM(WriteDataM),
        .MemAddr(MemAddr),
        .MemWE(MemWE),
        .MemWD(MemWD),
        .MemRD(MemRD),
        .ReadDataM(ReadDataM),
        .StallM(StallM),
        .DoneM(DoneM),
        .StallCycles(StallCycles)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wd;
    } acc_t;

    typedef struct packed {
        logic [R*N-1:0] rd;
        logic [31:0]    len;
        logic [31:0]    stall;
    } done_t;

    acc_t                accQ[$];
    done_t               doneQ[$];
    int                  checks = 0;
    int                  failures = 0;
    int                  stallRun = 0;
    int                  totalWrites = 0;
    logic [7:0]          ram[256];
    logic [7:0]          refMem[256];
    logic [R-1:0][N-1:0] refRd;
    logic [31:0]         refStall;
    acc_t                monAcc;
    done_t               monDone;

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous data memory: one-cycle read latency, write on enable.
    always @(posedge clk) begin
        MemRD <= ram[MemAddr[7:0]];
        if (MemWE) ram[MemAddr[7:0]] = MemWD;
    end

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: lane accesses live in stall-run cycles 1..R; completion pops a record.
    always @(negedge clk) begin
        if (MemWE) totalWrites++;
        if (StallM && stallRun >= 1 && stallRun <= R) begin
            if (accQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_access actual_addr=%h required=none", MemAddr);
            end else begin
                monAcc = accQ.pop_front();
                checkOutput("lane_addr", 64'(MemAddr), 64'(monAcc.addr));
                checkOutput("lane_we", 64'(MemWE), 64'(monAcc.we));
                checkOutput("lane_wd", 64'(MemWD), 64'(monAcc.wd));
            end
        end else begin
            checkOutput("quiet_we", 64'(MemWE), 64'd0);
            checkOutput("quiet_addr", 64'(MemAddr), 64'd0);
            checkOutput("quiet_wd", 64'(MemWD), 64'd0);
        end
        if (DoneM) begin
            if (doneQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 required=0");
            end else begin
                monDone = doneQ.pop_front();
                checkOutput("done_readdata", 64'(ReadDataM), 64'(monDone.rd));
                checkOutput("done_stall_len", 64'(stallRun), 64'(monDone.len));
                checkOutput("done_stallcycles", 64'(StallCycles), 64'(monDone.stall));
                checkOutput("done_stallm_low", 64'(StallM), 64'd0);
            end
            stallRun = 0;
        end else if (StallM) begin
            stallRun++;
        end
        if (reset) stallRun = 0;
    end

    // Issue one vector access, record expectations, hold the request until DONE.
    task automatic applyStimulus(input bit st, input logic [31:0] addr, input logic [R-1:0][N-1:0] wd);
        acc_t        a;
        done_t       d;
        logic [31:0] la;
        bit          seen;
        MemReqM    = 1'b1;
        MemWriteM  = st;
        AddrM      = addr;
        WriteDataM = wd;
        for (int k = 0; k < R; k++) begin
            la     = addr + 32'(k);
            a.addr = la;
            a.we   = st;
            a.wd   = st ? wd[k] : 8'h00;
            accQ.push_back(a);
            if (st) refMem[la[7:0]] = wd[k];
            else    refRd[k] = refMem[la[7:0]];
        end
        refStall = refStall + (st ? 32'(R + 1) : 32'(R + 2));
        d.rd  = refRd;
        d.len = st ? 32'(R + 1) : 32'(R + 2);
`ifdef VMEM_SEQ_PERF_EN
        d.stall = refStall;
`else
        d.stall = 32'd0;
`endif
        doneQ.push_back(d);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (DoneM) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual=no_done required=done_within_40");
        end
        @(posedge clk);
        #1;
        MemReqM = 1'b0;
    endtask

    task automatic doReset();
        reset   = 1'b1;
        MemReqM = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        refRd    = '0;
        refStall = 32'd0;
    endtask

    function automatic logic [R-1:0][N-1:0] randVec();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[R*N-1:0];
    endfunction

    // Main stimulus sequence.
    initial begin
        logic [R-1:0][N-1:0] wd;
        int                  w0;
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 8'($urandom());
            refMem[i] = ram[i];
        end
        for (int k = 0; k < R; k++) begin
            ram[8'h10 + k]    = 8'hA0 + 8'(k);
            refMem[8'h10 + k] = 8'hA0 + 8'(k);
        end
        reset      = 1'b1;
        MemReqM    = 1'b0;
        MemWriteM  = 1'b0;
        AddrM      = '0;
        WriteDataM = '0;
        refRd      = '0;
        refStall   = 32'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_we", 64'(MemWE), 64'd0);
        checkOutput("reset_addr", 64'(MemAddr), 64'd0);
        checkOutput("reset_readdata", 64'(ReadDataM), 64'd0);
        checkOutput("reset_stallm", 64'(StallM), 64'd0);
        checkOutput("reset_donem", 64'(DoneM), 64'd0);
        checkOutput("reset_stallcycles", 64'(StallCycles), 64'd0);
        #2 MemReqM = 1'b1;
        #1 checkOutput("reset_stall_follows_req", 64'(StallM), 64'd1);
        MemReqM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] directed load at 0x10");
        applyStimulus(1'b0, 32'h0000_0010, '0);
        checkOutput("load10_lanes", 64'(ReadDataM), 64'h0000_A5A4_A3A2_A1A0);

        $display("[TB] directed store at 0x20");
        wd = {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        applyStimulus(1'b1, 32'h0000_0020, wd);

        $display("[TB] wrapping load at 0xFFFFFFFE");
        applyStimulus(1'b0, 32'hFFFF_FFFE, '0);

        $display("[TB] back-to-back load then store after reset");
        doReset();
        applyStimulus(1'b0, $urandom(), '0);
        applyStimulus(1'b1, $urandom(), randVec());

        $display("[TB] reset during third store access");
        wd         = randVec();
        w0         = totalWrites;
        MemReqM    = 1'b1;
        MemWriteM  = 1'b1;
        AddrM      = 32'h0000_0040;
        WriteDataM = wd;
        for (int k = 0; k < 3; k++) begin
            accQ.push_back({32'h0000_0040 + 32'(k), 1'b1, wd[k]});
            refMem[8'h40 + k] = wd[k];
        end
        @(posedge clk); #1; MemReqM = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        refRd    = '0;
        refStall = 32'd0;
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("abort_write_count", 64'(totalWrites), 64'(w0 + 3));
        checkOutput("abort_accq_drained", 64'(accQ.size()), 64'd0);
        checkOutput("abort_idle_stallm", 64'(StallM), 64'd0);
        checkOutput("abort_idle_we", 64'(MemWE), 64'd0);
        applyStimulus(1'b1, 32'h0000_0080, randVec());

        $display("[TB] randomized traffic");
        for (int t = 0; t < 24; t++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom(), randVec());
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (5) begin @(posedge clk); #1; end
        checkOutput("final_accq_empty", 64'(accQ.size()), 64'd0);
        checkOutput("final_doneq_empty", 64'(doneQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
